// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM widths, direction encodings and controller FSM states
package ram_pkg;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/ram_access_master_if.sv
// rtl/ram_access_master_if.sv - client request/response channels plus RAM pin bundle
interface ram_access_master_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              mem_read_write;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;

  // master: the controller itself; slave: the client together with the RAM
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_out,
    output req_ready, rsp_valid, rsp_write, rsp_data, busy,
           mem_read_write, mem_en, mem_address, mem_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_out,
    input  req_ready, rsp_valid, rsp_write, rsp_data, busy,
           mem_read_write, mem_en, mem_address, mem_in
  );
endinterface

// File: rtl/ram_access_timer.sv
// rtl/ram_access_timer.sv - loadable down-counter flagging the last cycle of an access
module ram_access_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count of 1 means the current enabled cycle is the final one
  assign done_o = en_i && (cnt_q == CNT_W'(1));
endmodule

// File: rtl/ram_access_master.sv
// rtl/ram_access_master.sv - sequences one RAM read/write per client command with registered outputs
module ram_access_master
  import ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_HOLD = 1
) (
  input logic               clk,
  input logic               rst_n,
  ram_access_master_if.master bus
);
  localparam int MAX_N = (READ_WAIT > WRITE_HOLD) ? READ_WAIT : WRITE_HOLD;
  localparam int CNT_W = $clog2(MAX_N + 1);

  if (READ_WAIT < 1 || WRITE_HOLD < 1) begin : g_bad_timing
    $error("ram_access_master: READ_WAIT and WRITE_HOLD must be at least 1");
  end

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;

  logic             timer_load;
  logic             timer_en;
  logic             timer_done;
  logic [CNT_W-1:0] timer_val;

  assign timer_load = (state_q == ST_SETUP);
  assign timer_en   = (state_q == ST_ACCESS);
  assign timer_val  = (mem_rw_q == RW_WRITE) ? CNT_W'(WRITE_HOLD) : CNT_W'(READ_WAIT);

  ram_access_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    mem_rw_d    = mem_rw_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_in_d    = mem_in_q;

    unique case (state_q)
      ST_IDLE: begin
        // The mem_* registers double as the command latch, so SETUP already sees them
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        mem_en_d    = 1'b0;
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          mem_addr_d  = bus.req_addr;
          mem_in_d    = bus.req_wdata;
          mem_rw_d    = bus.req_write;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        mem_en_d = 1'b1;
      end
      ST_ACCESS: begin
        if (timer_done) begin
          state_d     = ST_RESP;
          mem_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = mem_rw_q;
          rsp_data_d  = (mem_rw_q == RW_WRITE) ? mem_in_q : bus.mem_out;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      mem_rw_q    <= mem_rw_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_in_q    <= mem_in_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_write      = rsp_write_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.busy           = busy_q;
  assign bus.mem_read_write = mem_rw_q;
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_in         = mem_in_q;
endmodule

// File: tb/tb_ram_access_master.sv
// tb/tb_ram_access_master.sv - directed and random checks of ram_access_master against a reference RAM model
module tb_ram_access_master;
  import ram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   n_cmp = 0;
  int   n_err = 0;

  ram_access_master_if #(.ADDR_W(2), .DATA_W(4)) a1 ();
  ram_access_master_if #(.ADDR_W(2), .DATA_W(4)) a3 ();

  ram_access_master #(.ADDR_W(2), .DATA_W(4), .READ_WAIT(1), .WRITE_HOLD(1))
    dut1 (.clk(clk), .rst_n(rst1), .bus(a1));
  ram_access_master #(.ADDR_W(2), .DATA_W(4), .READ_WAIT(3), .WRITE_HOLD(1))
    dut3 (.clk(clk), .rst_n(rst3), .bus(a3));

  // Behavioural single-port RAMs hanging off each controller
  logic [3:0] ram1 [4];
  logic [3:0] ram3 [4];
  always @(posedge clk) if (a1.mem_en && a1.mem_read_write) ram1[a1.mem_address] <= a1.mem_in;
  always @(posedge clk) if (a3.mem_en && a3.mem_read_write) ram3[a3.mem_address] <= a3.mem_in;
  assign a1.mem_out = (a1.mem_en && !a1.mem_read_write) ? ram1[a1.mem_address] : 4'h0;
  assign a3.mem_out = (a3.mem_en && !a3.mem_read_write) ? ram3[a3.mem_address] : 4'h0;

  // Reference contents: what a client should read back after its own writes
  logic [3:0] ref_mem [2][4];
  logic       written [2][4];

  typedef struct packed {
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_write;
    logic [3:0] rsp_data;
    logic       busy;
    logic       mem_rw;
    logic       mem_en;
    logic [1:0] mem_addr;
    logic [3:0] mem_in;
  } obs_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int sel, output obs_t o);
    if (sel == 0)
      o = {a1.req_ready, a1.rsp_valid, a1.rsp_write, a1.rsp_data, a1.busy,
           a1.mem_read_write, a1.mem_en, a1.mem_address, a1.mem_in};
    else
      o = {a3.req_ready, a3.rsp_valid, a3.rsp_write, a3.rsp_data, a3.busy,
           a3.mem_read_write, a3.mem_en, a3.mem_address, a3.mem_in};
  endtask

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [1:0] a, input logic [3:0] d);
    if (sel == 0) begin
      a1.req_valid = v; a1.req_write = w; a1.req_addr = a; a1.req_wdata = d;
    end else begin
      a3.req_valid = v; a3.req_write = w; a3.req_addr = a; a3.req_wdata = d;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) a1.rsp_ready = v;
    else          a3.rsp_ready = v;
  endtask

  // One full command: accept, setup, n enabled cycles, response held `hold` cycles
  task automatic txn(input int sel, input logic w, input logic [1:0] a,
                     input logic [3:0] d, input int hold, input int n);
    obs_t       o;
    int         lat, en_cnt, first_en;
    logic [3:0] exp;
    exp = w ? d : ref_mem[sel][a];
    drive(sel, 1'b1, w, a, d);
    snap(sel, o);
    chk("idle_req_ready", o.req_ready, 1);
    @(negedge clk);
    drive(sel, 1'b0, w, a, d);
    snap(sel, o);
    chk("setup_state", {o.mem_en, o.mem_addr, o.mem_rw, o.busy, o.req_ready},
        {1'b0, a, w, 1'b1, 1'b0});
    if (w) chk("setup_mem_in", o.mem_in, d);
    lat = 1; en_cnt = 0; first_en = 0;
    while (!o.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      snap(sel, o);
      if (o.mem_en) begin
        en_cnt++;
        if (first_en == 0) first_en = lat;
        chk("access_stable", {o.mem_addr, o.mem_rw}, {a, w});
      end
    end
    chk("rsp_latency", lat, 2 + n);
    chk("en_cycles", en_cnt, n);
    chk("en_first_cycle", first_en, 2);
    chk("rsp_write", o.rsp_write, w);
    chk("rsp_data", o.rsp_data, exp);
    chk("rsp_mem_en", o.mem_en, 0);
    if (w) begin
      ref_mem[sel][a] = d;
      written[sel][a] = 1'b1;
    end
    // While backpressured, a competing command must be ignored
    if (hold > 0) drive(sel, 1'b1, ~w, a + 2'd1, ~d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      snap(sel, o);
      chk("bp_hold", {o.rsp_valid, o.rsp_data, o.req_ready, o.mem_en, o.mem_addr},
          {1'b1, exp, 1'b0, 1'b0, a});
    end
    drive(sel, 1'b0, w, a, d);
    set_rr(sel, 1'b1);
    @(negedge clk);
    set_rr(sel, 1'b0);
    snap(sel, o);
    chk("rsp_release", {o.rsp_valid, o.req_ready, o.busy}, {1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    obs_t       o;
    int         waited;
    logic       seen;
    logic       w;
    logic [1:0] a;
    logic [3:0] d;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) begin
        ref_mem[s][i] = 4'h0;
        written[s][i] = 1'b0;
      end
    rst1 = 1'b0; rst3 = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 4'h0);
    set_rr(0, 1'b0); set_rr(1, 1'b0);

    // Power-on reset
    repeat (3) @(negedge clk);
    snap(0, o); chk("por_outs_dut1", o, 0);
    snap(1, o); chk("por_outs_dut3", o, 0);
    rst1 = 1'b1; rst3 = 1'b1;
    @(negedge clk);
    snap(0, o); chk("por_release_dut1", {o.req_ready, o.busy}, 2'b10);
    snap(1, o); chk("por_release_dut3", {o.req_ready, o.busy}, 2'b10);

    // Single write, then fill 0..3 and read back in reverse
    txn(0, 1'b1, 2'd2, 4'hA, 0, 1);
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 2'(i), 4'(5 + i), 0, 1);
    for (int i = 3; i >= 0; i--) txn(0, 1'b0, 2'(i), 4'h0, 0, 1);

    // Long backpressure on a read
    txn(0, 1'b0, 2'd1, 4'h0, 10, 1);

    // Reset while a response is pending: it must vanish
    drive(0, 1'b1, 1'b0, 2'd0, 4'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 4'h0);
    waited = 0;
    snap(0, o);
    while (!o.rsp_valid && waited < 20) begin
      @(negedge clk); waited++; snap(0, o);
    end
    chk("pre_reset_rsp", o.rsp_valid, 1);
    rst1 = 1'b0;
    #1;
    snap(0, o); chk("midreset_outs", o, 0);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    snap(0, o); chk("midreset_release", {o.req_ready, o.busy, o.rsp_valid}, 3'b100);

    // READ_WAIT=3 instance
    d = 4'($urandom);
    txn(1, 1'b1, 2'd1, d, 0, 1);
    txn(1, 1'b0, 2'd1, 4'h0, 0, 3);

    // Abort a 3-cycle read in its second enabled cycle
    drive(1, 1'b1, 1'b0, 2'd1, 4'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'd1, 4'h0);
    @(negedge clk);
    @(negedge clk);
    snap(1, o); chk("abort_pre_en", o.mem_en, 1);
    rst3 = 1'b0;
    #1;
    snap(1, o); chk("abort_outs", o, 0);
    @(negedge clk);
    rst3 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      snap(1, o);
      if (o.rsp_valid || o.mem_en) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_idle", {o.req_ready, o.busy}, 2'b10);

    // Randomised traffic on both instances
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom); a = 2'($urandom); d = 4'($urandom);
      txn(0, w, a, d, $urandom_range(0, 3), 1);
    end
    for (int k = 0; k < 12; k++) begin
      w = 1'($urandom); a = 2'($urandom); d = 4'($urandom);
      if (!w && !written[1][a]) w = 1'b1;
      txn(1, w, a, d, $urandom_range(0, 3), w ? 1 : 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
